// File: rtl/rasterize.sv
// rasterize: bounding-box triangle rasterizer, one candidate pixel per clock.
// Covered pixels (either winding, edges and vertices inclusive) leave as {x, y, shade}.
module rasterize #(
  parameter int SCREEN_W = 1024,
  parameter int SCREEN_H = 768
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [63:0] model_in,
  output logic        valid,
  output logic [27:0] pixel_out
);

  localparam logic [9:0] X_LIM = 10'(SCREEN_W - 1);
  localparam logic [9:0] Y_LIM = 10'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN} state_t;
  state_t state, state_next;

  logic [3:0]         col;
  logic [9:0]         x0, y0, x1, y1, x2, y2;
  logic [9:0]         xmin, xmax, ymax;
  logic [9:0]         px, py;
  logic [9:0]         bb_xmin, bb_xmax, bb_ymin, bb_ymax;
  logic signed [23:0] area, e01, e12, e20;
  logic               covered, last;

  function automatic logic [9:0] min3(input logic [9:0] a, b, c);
    logic [9:0] m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, b, c);
    logic [9:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  function automatic logic [9:0] clamp(input logic [9:0] v, lim);
    return (v > lim) ? lim : v;
  endfunction

  // Edge function of (p) against the directed edge a->b; 24 bits holds any 10-bit case.
  function automatic logic signed [23:0] edge_fn(input logic [9:0] ax, ay, bx, by, qx, qy);
    logic signed [23:0] dxb, dyb, dxq, dyq;
    dxb = $signed({14'd0, bx}) - $signed({14'd0, ax});
    dyb = $signed({14'd0, by}) - $signed({14'd0, ay});
    dxq = $signed({14'd0, qx}) - $signed({14'd0, ax});
    dyq = $signed({14'd0, qy}) - $signed({14'd0, ay});
    return dxb * dyq - dyb * dxq;
  endfunction

  always_comb begin
    bb_xmin = clamp(min3(x0, x1, x2), X_LIM);
    bb_xmax = clamp(max3(x0, x1, x2), X_LIM);
    bb_ymin = clamp(min3(y0, y1, y2), Y_LIM);
    bb_ymax = clamp(max3(y0, y1, y2), Y_LIM);
    area    = edge_fn(x0, y0, x1, y1, x2, y2);
    e01     = edge_fn(x0, y0, x1, y1, px, py);
    e12     = edge_fn(x1, y1, x2, y2, px, py);
    e20     = edge_fn(x2, y2, x0, y0, px, py);
    covered = (e01 >= 24'sd0 && e12 >= 24'sd0 && e20 >= 24'sd0) ||
              (e01 <= 24'sd0 && e12 <= 24'sd0 && e20 <= 24'sd0);
    last    = (px == xmax) && (py == ymax);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in) state_next = SETUP;
      SETUP:   state_next = (area == 24'sd0) ? IDLE : SCAN;
      SCAN:    if (last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Triangle capture, bounding-box setup and the row-major scan walk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col       <= '0;
      x0        <= '0;
      y0        <= '0;
      x1        <= '0;
      y1        <= '0;
      x2        <= '0;
      y2        <= '0;
      xmin      <= '0;
      xmax      <= '0;
      ymax      <= '0;
      px        <= '0;
      py        <= '0;
      valid     <= 1'b0;
      pixel_out <= '0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            col <= model_in[63:60];
            x0  <= model_in[59:50];
            y0  <= model_in[49:40];
            x1  <= model_in[39:30];
            y1  <= model_in[29:20];
            x2  <= model_in[19:10];
            y2  <= model_in[9:0];
          end
        end
        SETUP: begin
          xmin <= bb_xmin;
          xmax <= bb_xmax;
          ymax <= bb_ymax;
          px   <= bb_xmin;
          py   <= bb_ymin;
        end
        SCAN: begin
          valid <= covered;
          if (covered) pixel_out <= {px, py, col, col};
          if (px == xmax) begin
            px <= xmin;
            py <= py + 10'd1;
          end else begin
            px <= px + 10'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rasterize.sv
// tb_rasterize: table vectors, hand-written corner sequences and random triangles
// checked against a loop-over-bounding-box reference model.
module tb_rasterize;

  localparam int SCREEN_W = 1024;
  localparam int SCREEN_H = 768;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [63:0] model_in = '0;
  logic        valid;
  logic [27:0] pixel_out;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  int          obs_cyc[$];
  logic [27:0] obs_pix[$];
  int          exp_cyc[$];
  logic [27:0] exp_pix[$];

  typedef struct {
    logic [63:0] model;
    int          exp_count;
    logic [27:0] first_pix;
    logic [27:0] last_pix;
    string       name;
  } vec_t;

  vec_t vecs[5];

  rasterize #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H)) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .model_in(model_in),
    .valid(valid),
    .pixel_out(pixel_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst && valid) begin
      obs_cyc.push_back(cyc);
      obs_pix.push_back(pixel_out);
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [63:0] tri_pack(input int c, x0, y0, x1, y1, x2, y2);
    logic [3:0] cc;
    logic [9:0] a, b, d, e, f, g;
    cc = c[3:0]; a = x0[9:0]; b = y0[9:0]; d = x1[9:0]; e = y1[9:0]; f = x2[9:0]; g = y2[9:0];
    return {cc, a, b, d, e, f, g};
  endfunction

  function automatic longint orient(input int ax, ay, bx, by, qx, qy);
    return longint'(bx - ax) * longint'(qy - ay) - longint'(by - ay) * longint'(qx - ax);
  endfunction

  // Reference: every pixel of the clamped box in row-major order, kept if all three
  // cross products agree in sign; candidate i lands after edge k+2+i.
  task automatic modelTriangle(input logic [63:0] m, input int k, output int n);
    int vx[3], vy[3];
    int c, xlo, xhi, ylo, yhi, idx;
    longint e0, e1, e2;
    logic [9:0] xs, ys;
    logic [3:0] cs;
    c = int'(m[63:60]);
    vx[0] = int'(m[59:50]); vy[0] = int'(m[49:40]);
    vx[1] = int'(m[39:30]); vy[1] = int'(m[29:20]);
    vx[2] = int'(m[19:10]); vy[2] = int'(m[9:0]);
    xlo = 5000; xhi = -1; ylo = 5000; yhi = -1;
    for (int i = 0; i < 3; i++) begin
      if (vx[i] < xlo) xlo = vx[i];
      if (vx[i] > xhi) xhi = vx[i];
      if (vy[i] < ylo) ylo = vy[i];
      if (vy[i] > yhi) yhi = vy[i];
    end
    if (xlo > SCREEN_W - 1) xlo = SCREEN_W - 1;
    if (xhi > SCREEN_W - 1) xhi = SCREEN_W - 1;
    if (ylo > SCREEN_H - 1) ylo = SCREEN_H - 1;
    if (yhi > SCREEN_H - 1) yhi = SCREEN_H - 1;
    if (orient(vx[0], vy[0], vx[1], vy[1], vx[2], vy[2]) == 0) begin
      n = 0;
      return;
    end
    n = (xhi - xlo + 1) * (yhi - ylo + 1);
    idx = 0;
    cs = c[3:0];
    for (int y = ylo; y <= yhi; y++) begin
      for (int x = xlo; x <= xhi; x++) begin
        e0 = orient(vx[0], vy[0], vx[1], vy[1], x, y);
        e1 = orient(vx[1], vy[1], vx[2], vy[2], x, y);
        e2 = orient(vx[2], vy[2], vx[0], vy[0], x, y);
        if ((e0 >= 0 && e1 >= 0 && e2 >= 0) || (e0 <= 0 && e1 <= 0 && e2 <= 0)) begin
          xs = x[9:0];
          ys = y[9:0];
          exp_cyc.push_back(k + 2 + idx);
          exp_pix.push_back({xs, ys, cs, cs});
        end
        idx++;
      end
    end
  endtask

  task automatic clearQueues();
    obs_cyc.delete(); obs_pix.delete();
    exp_cyc.delete(); exp_pix.delete();
  endtask

  task automatic applyStimulus(input logic [63:0] m, output int k, output int n);
    @(negedge clk);
    valid_in = 1'b1;
    model_in = m;
    k = cyc + 1;
    modelTriangle(m, k, n);
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic checkOutput(input string name);
    int lim;
    check({name, "_count"}, 64'(obs_pix.size()), 64'(exp_pix.size()));
    lim = (obs_pix.size() < exp_pix.size()) ? obs_pix.size() : exp_pix.size();
    for (int i = 0; i < lim; i++) begin
      checks++;
      if (obs_cyc[i] != exp_cyc[i] || obs_pix[i] !== exp_pix[i]) begin
        errors++;
        $display("[TB] FAIL %s_pixel%0d: got %07h at cycle %0d expected %07h at cycle %0d",
                 name, i, obs_pix[i], obs_cyc[i], exp_pix[i], exp_cyc[i]);
        break;
      end
    end
  endtask

  task automatic runTriangle(input logic [63:0] m, input string name, output int k, output int n);
    clearQueues();
    applyStimulus(m, k, n);
    repeat (n + 4) @(negedge clk);
    checkOutput(name);
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int k, n, k2, n2, maxy;
    logic [63:0] sweep, t2, m;

    vecs[0] = '{tri_pack(10, 0, 0, 3, 0, 0, 3), 10, 28'h00000AA, 28'h00003AA, "sweep"};
    vecs[1] = '{tri_pack(10, 0, 0, 0, 3, 3, 0), 10, 28'h00000AA, 28'h00003AA, "swapped"};
    vecs[2] = '{tri_pack(6, 0, 0, 5, 5, 10, 10), 0, 28'h0, 28'h0, "collinear"};
    vecs[3] = '{tri_pack(3, 2, 2, 2, 5, 5, 2), 10, 28'h0080233, 28'h0080533, "small"};
    vecs[4] = '{tri_pack(9, 1020, 760, 1023, 1000, 1015, 765), -1, 28'h0, 28'h0, "clamp"};

    // Reset asserted mid-cycle, then idle with no triangle.
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("reset_valid", 64'(valid), 64'(1'b0));
    check("reset_pixel", 64'(pixel_out), 64'(28'h0));
    @(negedge clk);
    rst = 1'b1;
    clearQueues();
    repeat (10) @(negedge clk);
    check("idle_no_pixels", 64'(obs_pix.size()), 64'(0));
    check("idle_valid", 64'(valid), 64'(1'b0));
    check("idle_pixel", 64'(pixel_out), 64'(28'h0));

    for (int v = 0; v < 5; v++) begin
      runTriangle(vecs[v].model, vecs[v].name, k, n);
      if (vecs[v].exp_count >= 0)
        check({vecs[v].name, "_hand_count"}, 64'(obs_pix.size()), 64'(vecs[v].exp_count));
      if (vecs[v].exp_count > 0 && obs_pix.size() > 0) begin
        check({vecs[v].name, "_first"}, 64'(obs_pix[0]), 64'(vecs[v].first_pix));
        check({vecs[v].name, "_last"}, 64'(obs_pix[obs_pix.size()-1]), 64'(vecs[v].last_pix));
      end
      if (vecs[v].name == "clamp") begin
        maxy = 0;
        foreach (obs_pix[i]) if (int'(obs_pix[i][17:8]) > maxy) maxy = int'(obs_pix[i][17:8]);
        check("clamp_max_y_le_767", 64'(maxy <= SCREEN_H - 1), 64'(1));
      end
    end

    // Reference triangle: first pixel at k+2, row 3 only x=64, row 4 x=64..65.
    runTriangle(64'h0410C21000C10003, "spec_tri", k, n);
    if (obs_pix.size() >= 3) begin
      check("spec_first_pix", 64'(obs_pix[0]), 64'(28'h1000300));
      check("spec_first_cyc", 64'(obs_cyc[0]), 64'(k + 2));
      check("spec_row4_a", 64'(obs_pix[1]), 64'(28'h1000400));
      check("spec_row4_a_cyc", 64'(obs_cyc[1]), 64'(k + 2 + 197));
      check("spec_row4_b", 64'(obs_pix[2]), 64'(28'h1040400));
    end else begin
      check("spec_min_pixels", 64'(obs_pix.size()), 64'(3));
    end

    // Back-to-back: new triangle sampled in the first IDLE cycle after the scan.
    sweep = tri_pack(10, 0, 0, 3, 0, 0, 3);
    t2 = tri_pack(1, 100, 100, 104, 100, 100, 104);
    clearQueues();
    applyStimulus(sweep, k, n);
    check("sweep_candidates", 64'(n), 64'(16));
    while (cyc < k + n + 1) @(negedge clk);
    valid_in = 1'b1;
    model_in = t2;
    k2 = cyc + 1;
    modelTriangle(t2, k2, n2);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (n2 + 4) @(negedge clk);
    checkOutput("back_to_back");

    // Degenerate: ready again two cycles after acceptance.
    clearQueues();
    applyStimulus(tri_pack(6, 0, 0, 5, 5, 10, 10), k, n);
    while (cyc < k + 1) @(negedge clk);
    valid_in = 1'b1;
    model_in = t2;
    k2 = cyc + 1;
    modelTriangle(t2, k2, n2);
    @(negedge clk);
    valid_in = 1'b0;
    repeat (n2 + 4) @(negedge clk);
    checkOutput("after_degenerate");

    // Busy: a second triangle offered during SCAN is dropped.
    clearQueues();
    applyStimulus(sweep, k, n);
    while (cyc < k + 3) @(negedge clk);
    valid_in = 1'b1;
    model_in = t2;
    @(negedge clk);
    valid_in = 1'b0;
    repeat (n + 4) @(negedge clk);
    checkOutput("busy_drop");

    // Reset mid-scan aborts; the next triangle starts at its own corner.
    clearQueues();
    applyStimulus(tri_pack(5, 0, 0, 20, 0, 0, 20), k, n);
    while (cyc < k + 30) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("midscan_reset_valid", 64'(valid), 64'(1'b0));
    check("midscan_reset_pixel", 64'(pixel_out), 64'(28'h0));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    obs_cyc.delete(); obs_pix.delete();
    repeat (10) @(negedge clk);
    check("midscan_no_pixels", 64'(obs_pix.size()), 64'(0));
    runTriangle(tri_pack(7, 50, 60, 53, 60, 50, 63), "after_reset", k, n);
    if (obs_pix.size() > 0) check("after_reset_first", 64'(obs_pix[0]), 64'(28'h0C83C77));
    else check("after_reset_nonempty", 64'(obs_pix.size()), 64'(1));

    // Random small triangles anywhere on (and beyond) the screen.
    for (int r = 0; r < 8; r++) begin
      int bx, by;
      bx = int'($urandom_range(0, 1000));
      by = int'($urandom_range(0, 1008));
      m = tri_pack(int'($urandom_range(0, 15)),
                   bx + int'($urandom_range(0, 15)), by + int'($urandom_range(0, 15)),
                   bx + int'($urandom_range(0, 15)), by + int'($urandom_range(0, 15)),
                   bx + int'($urandom_range(0, 15)), by + int'($urandom_range(0, 15)));
      runTriangle(m, $sformatf("random%0d", r), k, n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rasterize.md
Name: rasterize

Overview:
- Triangle rasterizer for the AR card render path.
- Accepts one packed screen-space triangle (three 10-bit vertices plus a 4-bit colour) per handshake.
- Scans the triangle's clamped bounding box row-major, one candidate pixel per clock.
- Emits a valid-qualified pixel word (x, y, shade) for every pixel inside or on the triangle, for the downstream pixel writer.

Parameters:
- SCREEN_W, 1024, horizontal resolution; x coordinates are clamped to [0, SCREEN_W-1].
- SCREEN_H, 768, vertical resolution; y coordinates are clamped to [0, SCREEN_H-1].

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-low.
- valid_in  input  1  model_in carries a triangle this cycle.
- model_in  input  64  packed triangle: [63:60] colour c, [59:50] x0, [49:40] y0, [39:30] x1, [29:20] y1, [19:10] x2, [9:0] y2. All fields are unsigned.
- valid  output  1  pixel_out holds a covered pixel this cycle.
- pixel_out  output  28  {x[9:0], y[9:0], shade[7:0]}, where shade = {c, c}.

Behaviour:
- Reset (rst low, asynchronous): state=IDLE, valid=0, pixel_out=0, all internal registers cleared. Reset mid-scan aborts the triangle; no further pixels are emitted.
- The FSM has three states: IDLE, SETUP, SCAN.
- IDLE:
  - On a rising edge with valid_in=1, register the model_in fields and go to SETUP.
  - valid_in is ignored in SETUP and SCAN; no queueing, the triangle is dropped.
- SETUP (1 cycle):
  - Compute xmin/xmax/ymin/ymax over the three vertices, clamped to screen limits.
  - Compute the signed doubled area A = (x1-x0)(y2-y0) - (x2-x0)(y1-y0).
  - If A==0 (degenerate), return to IDLE and emit nothing.
  - Otherwise set the scan position to (xmin, ymin) and go to SCAN.
- SCAN, one candidate per cycle:
  - Evaluate three edge functions for the current (x, y): E01, E12, E20, with Eab = (xb-xa)(y-ya) - (yb-ya)(x-xa).
  - The pixel is covered iff all three edge functions are >=0, or all three are <=0. Both windings are accepted; edge and vertex pixels count as covered.
  - Arithmetic is signed, at least 24 bits wide, with no overflow for 10-bit coordinates.
  - Per-pixel multiplies or incremental adds are both acceptable, provided results are identical.
  - On the next edge: valid <= covered; pixel_out <= {x, y, shade} when covered, otherwise pixel_out holds its previous value.
  - Advance x; when x==xmax, wrap to x=xmin and y+1.
  - After evaluating (xmax, ymax), return to IDLE.
- Timing:
  - The edge sampling valid_in=1 is edge k. The candidate (xmin, ymin) result is visible after edge k+2.
  - The last candidate's result is visible after edge k+2+(xmax-xmin+1)(ymax-ymin+1)-1.
  - valid drops to 0 the cycle after the last candidate.
- Back-to-back triangles: valid_in sampled in the first IDLE cycle after the scan ends is accepted.
- valid is a 1-cycle strobe per covered pixel. There is no backpressure; the consumer must accept every pixel.

Test Plan:
- Reset then idle: assert rst low mid-cycle -> valid=0 and pixel_out=0 immediately; with valid_in=0 both stay 0 indefinitely.
- Single triangle: valid_in=1 for one cycle with model_in=64'h0410C21000C10003, giving c=0 and vertices (260,194), (64,12), (64,3).
  - valid=0 after edge k+1.
  - After edge k+2: valid=1, pixel_out=28'h1000300 (x=64, y=3, shade=0).
  - valid=0 for candidates x=65..260 of row y=3.
  - Row y=4 yields exactly x=64 and x=65.
- Coverage sweep: triangle (0,0), (3,0), (0,3), c=4'hA -> exactly 10 pixels, each with shade 8'hAA, in row-major order (0,0) (1,0) (2,0) (3,0) (0,1) (1,1) (2,1) (0,2) (1,2) (0,3). Then IDLE; total scan is 16 candidates.
- Winding and degenerate cases:
  - The same triangle with vertices 1 and 2 swapped -> identical pixel stream.
  - Collinear vertices (0,0), (5,5), (10,10) -> no valid pulses; ready again 2 cycles after acceptance.
- Busy and clamp:
  - A second valid_in during SCAN is ignored, and its pixels never appear.
  - A vertex at x=1023, y=1000 clamps ymax to 767; no pixel is emitted with y>767.
- Reset mid-scan: pull rst low during SCAN -> valid=0 at once. After release, a new triangle scans normally from its own (xmin, ymin).
